run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Run controller for the 9-bit single-cycle core. It owns the data-memory port, so an external host can load operands and read results while the core is idle. It launches the core from reset, watches the core's done flag under a cycle-count watchdog, then returns memory ownership to the host. It sits between the host/testbench, the core top and data_mem.

Parameters:
AW, 8, data-memory address width
DW, 8, data-memory data width
CW, 16, cycle-counter width
TIMEOUT, 4096, run-cycle limit before abort (must be < 2**CW)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse requesting a run
host_req  in  1  host memory access request
host_we  in  1  1 = write, 0 = read (qualified by host_req)
host_addr  in  AW  host memory address
host_wdata  in  DW  host write data
host_gnt  out  1  host access accepted this cycle
host_rdata  out  DW  registered read data
host_rvalid  out  1  host_rdata valid (one cycle)
core_mem_re  in  1  core data-memory read enable
core_mem_we  in  1  core data-memory write enable
core_mem_addr  in  AW  core data-memory address
core_mem_wdata  in  DW  core store data
core_mem_rdata  out  DW  load data returned to core
mem_re  out  1  to data_mem ReadMem
mem_we  out  1  to data_mem WriteMem
mem_addr  out  AW  to data_mem DataAddress
mem_wdata  out  DW  to data_mem DataIn
mem_rdata  in  DW  from data_mem DataOut (combinational read)
core_reset  out  1  active-high reset to core (IF Reset)
core_init  out  1  active-high halt to core (IF Halt)
core_done  in  1  core reached a terminal PC
busy  out  1  run in progress (PREP or RUN)
done  out  1  sticky: last run finished
timeout  out  1  sticky: last run aborted by watchdog
cycles  out  CW  clock cycles spent in RUN for the last or current run

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; core_reset=1, core_init=1, busy=0, done=0, timeout=0, cycles=0, host_rvalid=0, host_rdata=0, start_pend=0.
- States: IDLE, PREP, RUN, FIN.
- IDLE: host owns memory; core_reset=1, core_init=1. start or start_pend with host_req=0 -> PREP. start with host_req=1 -> set start_pend and stay in IDLE (the host transaction completes first).
- PREP (exactly 1 cycle): core_reset=1, core_init=1, mem_re=mem_we=0, host_gnt=0. Clear done, timeout, cycles and start_pend -> RUN.
- RUN: core_reset=0, core_init=0, core owns memory; busy=1. cycles increments every cycle and saturates at 2**CW-1.
  - core_done=1 -> FIN with done=1.
  - If cycles==TIMEOUT-1 and core_done=0 -> FIN with done=1, timeout=1.
  - If both occur in the same cycle, core_done wins and timeout stays 0.
- FIN: core_reset=0, core_init=1 (PC frozen, core registers preserved); host owns memory. start -> PREP under the same host_req deferral rule as IDLE.
- start in PREP or RUN is ignored and is not latched. core_done outside RUN is ignored.
- Memory mux:
  - Core owner: mem_* = core_*; core_mem_rdata = mem_rdata.
  - Host owner: mem_we = host_req&host_we, mem_re = host_req&~host_we, mem_addr = host_addr, mem_wdata = host_wdata; core_mem_rdata = 0.
  - PREP: mem_re=mem_we=0.
- Host handshake:
  - host_gnt = host_req while in IDLE or FIN, else 0.
  - A write commits on the granting edge.
  - For a granted read, host_rdata <= mem_rdata on that edge and host_rvalid=1 for the next cycle only.
  - An ungranted request must be held by the host until granted.
- Reset mid-run: immediate return to IDLE values; in-flight host read is dropped (host_rvalid=0).

Decomposition:
- definitions package: typedef enum logic[1:0] seq_state_t {IDLE, PREP, RUN, FIN}; localparam SEQ_TIMEOUT_DEF=4096.
- Sub-module sat_counter (CW parameter; clr, en, q) implements cycles. The FSM and memory mux stay in run_sequencer.

Test Plan:
- Reset, then host writes addr 0x10 = 0xA5 and reads it back -> host_gnt=1 both cycles; host_rvalid one cycle after the read with host_rdata=0xA5; core_reset=1 throughout.
- start pulse in IDLE, core_done driven 20 cycles into RUN -> PREP lasts 1 cycle; FIN with done=1, timeout=0, cycles=20, busy=0, core_init=1.
- TIMEOUT=8, core_done held 0 -> FIN after 8 RUN cycles with timeout=1, done=1, cycles=8; core_done at cycle 8 instead -> timeout=0.
- start and host_req asserted in the same IDLE cycle -> host access granted; PREP entered the cycle after host_req drops; start during RUN has no effect.
- During RUN, core_mem_we=1, addr 0x20, data 0x3C; host_req=1 -> host_gnt=0, mem_we=1, mem_addr=0x20; host later reads 0x20 in FIN -> 0x3C.
- reset asserted mid-RUN -> outputs immediately take their reset values (core_reset=1, busy=0, done=0, cycles=0); the next start runs normally.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: controller state encoding and the default watchdog limit.
package run_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } seq_state_t;

  localparam int SEQ_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with a synchronous clear. It holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core. It arbitrates the data-memory port between the host and the core,
// sequences core reset/halt around a run, and aborts a run with a cycle-count watchdog.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = SEQ_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          core_mem_re,
  input  logic          core_mem_we,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  output logic [DW-1:0] core_mem_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_reset,
  output logic          core_init,
  input  logic          core_done,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

  seq_state_t    state_q, state_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          start_pend_q, start_pend_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [CW-1:0] cycles_q;

  sat_counter #(.CW(CW)) u_cycles (
    .clk   (clk),
    .rst_n (reset),
    .clr   (state_q == PREP),
    .en    (state_q == RUN),
    .q     (cycles_q)
  );

  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    timeout_d      = timeout_q;
    start_pend_d   = start_pend_q;
    host_rdata_d   = host_rdata_q;
    host_rvalid_d  = 1'b0;
    core_reset     = 1'b1;
    core_init      = 1'b1;
    busy           = 1'b0;
    host_gnt       = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = host_addr;
    mem_wdata      = host_wdata;
    core_mem_rdata = '0;

    case (state_q)
      IDLE, FIN: begin
        // FIN keeps the core out of reset so its registers survive for inspection.
        core_reset = (state_q == IDLE);
        host_gnt   = host_req;
        mem_we     = host_req & host_we;
        mem_re     = host_req & ~host_we;
        if (host_req && !host_we) begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = mem_rdata;
        end
        // A start that collides with a host access waits until the host lets go.
        if (start || start_pend_q) begin
          if (host_req) begin
            start_pend_d = 1'b1;
          end else begin
            state_d = PREP;
          end
        end
      end

      PREP: begin
        busy         = 1'b1;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        start_pend_d = 1'b0;
        state_d      = RUN;
      end

      RUN: begin
        core_reset     = 1'b0;
        core_init      = 1'b0;
        busy           = 1'b1;
        mem_re         = core_mem_re;
        mem_we         = core_mem_we;
        mem_addr       = core_mem_addr;
        mem_wdata      = core_mem_wdata;
        core_mem_rdata = mem_rdata;
        // core_done takes priority over the watchdog when both land on the same cycle.
        if (core_done) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (cycles_q == LAST_CYCLE) begin
          state_d   = FIN;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      start_pend_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      start_pend_q  <= start_pend_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a long-watchdog instance with a data-memory model and a TIMEOUT=8 instance.
module tb_run_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, start8;
  logic        host_req, host_we;
  logic [7:0]  host_addr, host_wdata;
  logic        core_mem_re, core_mem_we;
  logic [7:0]  core_mem_addr, core_mem_wdata;
  logic        core_done, core_done8;
  logic [7:0]  mem8_rdata;

  logic        host_gnt, host_rvalid, mem_re, mem_we, core_reset, core_init, busy, done, timeout;
  logic [7:0]  host_rdata, core_mem_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] cycles;

  logic        t_host_gnt, t_host_rvalid, t_mem_re, t_mem_we, t_core_reset, t_core_init, t_busy, t_done, t_timeout;
  logic [7:0]  t_host_rdata, t_core_mem_rdata, t_mem_addr, t_mem_wdata;
  logic [15:0] t_cycles;

  logic [7:0]  mem [256];

  int n_cmp = 0;
  int n_err = 0;

  run_sequencer #(.AW(8), .DW(8), .CW(16), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .core_mem_re(core_mem_re), .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata), .core_mem_rdata(core_mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_reset(core_reset), .core_init(core_init), .core_done(core_done),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );

  run_sequencer #(.AW(8), .DW(8), .CW(16), .TIMEOUT(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(t_host_gnt), .host_rdata(t_host_rdata), .host_rvalid(t_host_rvalid),
    .core_mem_re(core_mem_re), .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata), .core_mem_rdata(t_core_mem_rdata),
    .mem_re(t_mem_re), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(mem8_rdata),
    .core_reset(t_core_reset), .core_init(t_core_init), .core_done(core_done8),
    .busy(t_busy), .done(t_done), .timeout(t_timeout), .cycles(t_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } hvec_t;

  hvec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    core_mem_re = 1'b0; core_mem_we = 1'b0; core_mem_addr = 8'h00; core_mem_wdata = 8'h00;
    core_done = 1'b0; core_done8 = 1'b0; mem8_rdata = 8'h00;

    vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 8'h11, 8'h5A, 8'h00};
    vecs[3] = '{1'b1, 8'h10, 8'hC3, 8'h00};
    vecs[4] = '{1'b0, 8'h11, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 8'h10, 8'h00, 8'hC3};
    vecs[6] = '{1'b1, 8'hFF, 8'h01, 8'h00};
    vecs[7] = '{1'b0, 8'hFF, 8'h00, 8'h01};

    // Reset values
    #2;
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_core_init",  32'(core_init), 1);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_done",       32'(done), 0);
    chk("rst_timeout",    32'(timeout), 0);
    chk("rst_cycles",     32'(cycles), 0);
    chk("rst_rvalid",     32'(host_rvalid), 0);
    chk("rst_rdata",      32'(host_rdata), 0);
    #9 rst_n = 1'b1;
    tick();

    // Host transactions while idle
    for (int i = 0; i < 8; i++) begin
      host_req = 1'b1; host_we = vecs[i].we; host_addr = vecs[i].addr; host_wdata = vecs[i].wdata;
      #3;
      chk($sformatf("v%0d_gnt", i),        32'(host_gnt), 1);
      chk($sformatf("v%0d_mem_we", i),     32'(mem_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_mem_re", i),     32'(mem_re), 32'(!vecs[i].we));
      chk($sformatf("v%0d_mem_addr", i),   32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_core_reset", i), 32'(core_reset), 1);
      chk($sformatf("v%0d_core_rdata", i), 32'(core_mem_rdata), 0);
      tick();
      host_req = 1'b0;
      chk($sformatf("v%0d_rvalid", i), 32'(host_rvalid), 32'(!vecs[i].we));
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), 32'(host_rdata), 32'(vecs[i].exp_rdata));
      tick();
      chk($sformatf("v%0d_rvalid_drop", i), 32'(host_rvalid), 0);
    end

    // Run 1: start from IDLE, core memory traffic, ignored start, done after 20 RUN cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    core_mem_we = 1'b1; host_req = 1'b1; host_we = 1'b1;
    #3;
    chk("prep_busy",       32'(busy), 1);
    chk("prep_core_reset", 32'(core_reset), 1);
    chk("prep_core_init",  32'(core_init), 1);
    chk("prep_mem_we",     32'(mem_we), 0);
    chk("prep_gnt",        32'(host_gnt), 0);
    core_mem_we = 1'b0; host_req = 1'b0;
    tick();
    chk("run_core_reset", 32'(core_reset), 0);
    chk("run_core_init",  32'(core_init), 0);
    chk("run_busy",       32'(busy), 1);
    chk("run_cycles0",    32'(cycles), 0);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        core_mem_we = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h3C;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hEE;
        #3;
        chk("run_host_gnt",  32'(host_gnt), 0);
        chk("run_mem_we",    32'(mem_we), 1);
        chk("run_mem_addr",  32'(mem_addr), 32'h20);
        chk("run_mem_wdata", 32'(mem_wdata), 32'h3C);
      end
      if (k == 6) begin
        core_mem_we = 1'b0; host_req = 1'b0; core_mem_re = 1'b1; core_mem_addr = 8'h20;
        #3;
        chk("run_mem_re",     32'(mem_re), 1);
        chk("run_core_rdata", 32'(core_mem_rdata), 32'h3C);
      end
      if (k == 10) begin
        start = 1'b1;
        chk("run_cycles10", 32'(cycles), 10);
      end
      if (k == 19) core_done = 1'b1;
      tick();
      start = 1'b0; core_done = 1'b0; core_mem_re = 1'b0;
    end
    chk("fin_done",       32'(done), 1);
    chk("fin_timeout",    32'(timeout), 0);
    chk("fin_cycles",     32'(cycles), 20);
    chk("fin_busy",       32'(busy), 0);
    chk("fin_core_init",  32'(core_init), 1);
    chk("fin_core_reset", 32'(core_reset), 0);
    tick();
    tick();
    chk("fin_start_ignored", 32'(busy), 0);
    chk("fin_cycles_hold",   32'(cycles), 20);

    // Host reads back the core's store while in FIN
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    #3;
    chk("fin_gnt",        32'(host_gnt), 1);
    chk("fin_core_rdata", 32'(core_mem_rdata), 0);
    tick();
    host_req = 1'b0;
    chk("fin_rvalid", 32'(host_rvalid), 1);
    chk("fin_rdata",  32'(host_rdata), 32'h3C);

    // Run 2, reset asserted mid-RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("run2_done_clr", 32'(done), 0);
    tick();
    tick();
    chk("run2_cycles2", 32'(cycles), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_core_reset", 32'(core_reset), 1);
    chk("mid_rst_core_init",  32'(core_init), 1);
    chk("mid_rst_busy",       32'(busy), 0);
    chk("mid_rst_done",       32'(done), 0);
    chk("mid_rst_cycles",     32'(cycles), 0);
    chk("mid_rst_rvalid",     32'(host_rvalid), 0);
    chk("mid_rst_rdata",      32'(host_rdata), 0);
    #2 rst_n = 1'b1;
    tick();

    // start together with a host read in IDLE: the read wins, PREP follows once host_req drops
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; start = 1'b1;
    #3;
    chk("defer_gnt", 32'(host_gnt), 1);
    tick();
    start = 1'b0;
    chk("defer_rvalid", 32'(host_rvalid), 1);
    chk("defer_rdata",  32'(host_rdata), 32'hC3);
    chk("defer_busy0",  32'(busy), 0);
    #3;
    chk("defer_gnt2", 32'(host_gnt), 1);
    tick();
    host_req = 1'b0;
    chk("defer_busy1", 32'(busy), 0);
    tick();
    chk("defer_prep_busy",  32'(busy), 1);
    chk("defer_prep_reset", 32'(core_reset), 1);
    tick();
    chk("defer_run_reset",  32'(core_reset), 0);
    chk("defer_run_cycles", 32'(cycles), 0);
    tick();
    tick();
    chk("defer_run_cycles2", 32'(cycles), 2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("defer_fin_done",    32'(done), 1);
    chk("defer_fin_timeout", 32'(timeout), 0);
    chk("defer_fin_cycles",  32'(cycles), 3);

    // Watchdog on the TIMEOUT=8 instance
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    repeat (7) tick();
    chk("wd_busy7",    32'(t_busy), 1);
    chk("wd_timeout7", 32'(t_timeout), 0);
    chk("wd_cycles7",  32'(t_cycles), 7);
    tick();
    chk("wd_done",      32'(t_done), 1);
    chk("wd_timeout",   32'(t_timeout), 1);
    chk("wd_cycles",    32'(t_cycles), 8);
    chk("wd_busy",      32'(t_busy), 0);
    chk("wd_core_init", 32'(t_core_init), 1);

    // core_done on the last allowed cycle beats the watchdog
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    chk("wd2_timeout_clr", 32'(t_timeout), 0);
    chk("wd2_cycles0",     32'(t_cycles), 0);
    repeat (7) tick();
    core_done8 = 1'b1;
    tick();
    core_done8 = 1'b0;
    chk("wd2_done",    32'(t_done), 1);
    chk("wd2_timeout", 32'(t_timeout), 0);
    chk("wd2_cycles",  32'(t_cycles), 8);
    chk("wd2_busy",    32'(t_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
